// File: rtl/aes_block_uart_sender.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_uart_sender
// Description : Serialises one AES result block into a byte stream for
//               uart_tx. Accepts a block on a valid/ready handshake, emits
//               one tx_start pulse per byte, waits for tx_done_tick between
//               bytes and marks the end of the block with a done tick.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_block_uart_sender #(
  parameter int BLOCK_BYTES     = 16,
  parameter int DATA_BIT_LENGTH = 8,
  parameter bit MSB_FIRST       = 1'b1,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_BIT_LENGTH*BLOCK_BYTES-1:0] block_i,
  input  logic                                   block_valid_i,
  output logic                                   block_ready_o,
  output logic [DATA_BIT_LENGTH-1:0]             byte_o,
  output logic                                   tx_start_o,
  input  logic                                   tx_done_tick_i,
  output logic                                   busy_o,
  output logic                                   done_tick_o
);

  localparam int BLOCK_W = DATA_BIT_LENGTH * BLOCK_BYTES;
  localparam int CNT_W   = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [BLOCK_W-1:0]         shift_q, shift_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic [DATA_BIT_LENGTH-1:0] byte_q, byte_d;
  logic                       tx_start_q, tx_start_d;
  logic                       done_q, done_d;

  // Shift register advanced by one byte, and the byte at its transmit end
  logic [BLOCK_W-1:0]         shift_adv;
  logic [DATA_BIT_LENGTH-1:0] head_byte;

  // The transmit end of the shift register depends on byte order
  if (MSB_FIRST) begin : g_msb_first
    assign shift_adv = shift_q << DATA_BIT_LENGTH;
    assign head_byte = shift_d[BLOCK_W-1 -: DATA_BIT_LENGTH];
  end else begin : g_lsb_first
    assign shift_adv = shift_q >> DATA_BIT_LENGTH;
    assign head_byte = shift_d[DATA_BIT_LENGTH-1:0];
  end

  // Ready/busy are pure state decodes so a block can be accepted in the
  // same cycle the previous block's done tick is visible
  assign block_ready_o = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign byte_o        = byte_q;
  assign tx_start_o    = tx_start_q;
  assign done_tick_o   = done_q;

  // Next-state logic: sequence the bytes of a block and pace them on tx_done
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    byte_d     = byte_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (block_valid_i) begin
          shift_d = block_i;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick_i) begin
          if (cnt_q == LAST_CNT) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            shift_d = shift_adv;
            cnt_d   = cnt_q + CNT_W'(1);
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? S_START : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_START;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The start pulse and its byte are registered on entry to S_START, so
    // tx_start_o is high exactly for the single S_START cycle and byte_o is
    // already valid in that cycle and held until the next start.
    if (state_d == S_START) begin
      tx_start_d = 1'b1;
      byte_d     = head_byte;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      byte_q     <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      byte_q     <= byte_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_block_uart_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_block_uart_sender
// Description : Self-checking bench for aes_block_uart_sender. Three
//               instances (MSB-first/gap 2, LSB-first/gap 2, MSB-first/gap 0)
//               run the same block stream against a cycle-level reference
//               model of byte order and start/done timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_block_uart_sender;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] block_i;
  logic         block_valid_i;
  logic         tdn [N];
  logic         rdy [N];
  logic [7:0]   byt [N];
  logic         txs [N];
  logic         bsy [N];
  logic         dtk [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    aes_block_uart_sender #(
      .BLOCK_BYTES    (16),
      .DATA_BIT_LENGTH(8),
      .MSB_FIRST      ((g == 1) ? 1'b0 : 1'b1),
      .GAP_CYCLES     ((g == 2) ? 0 : 2)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .block_i       (block_i),
      .block_valid_i (block_valid_i),
      .block_ready_o (rdy[g]),
      .byte_o        (byt[g]),
      .tx_start_o    (txs[g]),
      .tx_done_tick_i(tdn[g]),
      .busy_o        (bsy[g]),
      .done_tick_o   (dtk[g])
    );
  end

  int gap_of [N] = '{2, 2, 0};
  bit msb_of [N] = '{1'b1, 1'b0, 1'b1};

  int     total;
  int     bad;
  longint cyc;
  int     lat_cfg;
  bit     spur_en;

  // reference model state per instance
  bit           m_busy    [N];
  logic [127:0] m_blk     [N];
  int           m_idx     [N];
  longint       exp_start [N];
  longint       exp_done  [N];
  int           rem       [N];
  bit           spur_next [N];
  logic [7:0]   cur_exp   [N];
  logic [7:0]   first_byte[N];
  int           accepts   [N];
  int           start_cnt;

  typedef struct {
    logic [127:0] blk;
    int           lat;
    bit           spur;
    logic [7:0]   first_msb;
    logic [7:0]   first_lsb;
  } vec_t;

  // byte k of a block in transmit order
  function automatic logic [7:0] ref_byte(input logic [127:0] blk, input int k, input bit msb);
    int sh;
    sh = msb ? 8 * (15 - k) : 8 * k;
    return 8'((blk >> sh) & 128'hFF);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int i = 0; i < N; i++) if (m_busy[i]) r = 1'b0;
    return r;
  endfunction

  task automatic chk_eq(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_busy[i]    = 1'b0;
      m_blk[i]     = '0;
      m_idx[i]     = 0;
      exp_start[i] = -1;
      exp_done[i]  = -1;
      rem[i]       = 0;
      spur_next[i] = 1'b0;
      tdn[i]       = 1'b0;
    end
  endtask

  // compare one instance's outputs in the current cycle with the model
  task automatic check_inst(input int i);
    bit s, d, es, ed;
    s  = txs[i];
    d  = dtk[i];
    es = (exp_start[i] == cyc);
    ed = (exp_done[i] == cyc);
    if (s) start_cnt++;
    if (es || s) begin
      chk_eq("start_timing", i, s, es);
      if (es) begin
        cur_exp[i] = ref_byte(m_blk[i], m_idx[i], msb_of[i]);
        chk_eq("byte_value", i, byt[i], cur_exp[i]);
        chk_eq("ready_busy_at_start", i, {rdy[i], bsy[i]}, 2'b01);
        if (m_idx[i] == 0) first_byte[i] = byt[i];
        rem[i]       = lat_cfg + 1;
        exp_start[i] = -1;
      end
    end
    if (ed || d) begin
      chk_eq("done_timing", i, d, ed);
      chk_eq("done_start_overlap", i, s & d, 1'b0);
      if (ed) begin
        chk_eq("ready_busy_at_done", i, {rdy[i], bsy[i]}, 2'b10);
        exp_done[i] = -1;
        m_busy[i]   = 1'b0;
      end
    end
  endtask

  // uart_tx responder plus model advance for one instance
  task automatic model_step(input int i, input bit v, input logic [127:0] blk);
    tdn[i] = 1'b0;
    if (rem[i] > 0) begin
      rem[i]--;
      if (rem[i] == 0) begin
        tdn[i] = 1'b1;
        chk_eq("byte_hold", i, byt[i], cur_exp[i]);
        m_idx[i]++;
        if (m_idx[i] == 16) exp_done[i] = cyc + 1;
        else exp_start[i] = cyc + gap_of[i] + 1;
        spur_next[i] = spur_en && (gap_of[i] > 0);
      end
    end else if (spur_next[i]) begin
      tdn[i]       = 1'b1;
      spur_next[i] = 1'b0;
    end else if (spur_en && !m_busy[i] && $urandom_range(7) == 0) begin
      tdn[i] = 1'b1;
    end
    if (!m_busy[i] && v && !rst) begin
      m_busy[i]    = 1'b1;
      m_blk[i]     = blk;
      m_idx[i]     = 0;
      exp_start[i] = cyc + 1;
      accepts[i]++;
    end
  endtask

  // one clock cycle: check outputs, then drive inputs for this cycle's edge
  task automatic cycle(input bit v, input logic [127:0] blk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) check_inst(i);
    block_valid_i = v;
    block_i       = blk;
    for (int i = 0; i < N; i++) model_step(i, v, blk);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!all_idle() && n < limit) begin
      cycle(1'b0, rand128());
      n++;
    end
    chk_eq("idle_timeout", 0, all_idle(), 1'b1);
  endtask

  task automatic wait_byte(input int idx, input int limit);
    int n;
    n = 0;
    while (!(m_idx[0] == idx && rem[0] > 2) && n < limit) begin
      cycle(1'b0, rand128());
      n++;
    end
    chk_eq("byte_wait_timeout", 0, (m_idx[0] == idx && rem[0] > 2), 1'b1);
  endtask

  task automatic chk_reset_vals();
    for (int i = 0; i < N; i++)
      chk_eq("reset_outputs", i, {byt[i], txs[i], dtk[i], rdy[i], bsy[i]},
             {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         tbl [4];
    logic [127:0] a, b;
    int           acc0 [N];
    int           n;

    tbl[0] = '{128'h00112233445566778899AABBCCDDEEFF, 100, 1'b0, 8'h00, 8'hFF};
    tbl[1] = '{128'h0, 3, 1'b1, 8'h00, 8'h00};
    tbl[2] = '{{16{8'hFF}}, 1, 1'b1, 8'hFF, 8'hFF};
    tbl[3] = '{128'h800102030405060708090A0B0C0D0E7F, 5, 1'b1, 8'h80, 8'h7F};

    total = 0; bad = 0; cyc = 0; start_cnt = 0;
    lat_cfg = 4; spur_en = 1'b0;
    rst = 1'b1; block_valid_i = 1'b0; block_i = '0;
    for (int i = 0; i < N; i++) begin accepts[i] = 0; first_byte[i] = '0; cur_exp[i] = '0; end
    model_clear();

    // reset state
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    chk_reset_vals();
    rst = 1'b0;
    cycle(1'b0, '0);

    // table-driven blocks
    for (int t = 0; t < 4; t++) begin
      lat_cfg = tbl[t].lat;
      spur_en = tbl[t].spur;
      cycle(1'b1, tbl[t].blk);
      wait_idle(4000);
      for (int i = 0; i < N; i++)
        chk_eq("first_byte", i, first_byte[i], (i == 1) ? tbl[t].first_lsb : tbl[t].first_msb);
      cycle(1'b0, rand128());
    end

    // randomized blocks with random uart latency and spurious ticks
    spur_en = 1'b1;
    for (int t = 0; t < 5; t++) begin
      lat_cfg = $urandom_range(1, 8);
      cycle(1'b1, rand128());
      wait_idle(2000);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) cycle(1'b0, rand128());
    end

    // valid pulse with another block during byte 5 must be ignored
    lat_cfg = 6;
    a = rand128();
    cycle(1'b1, a);
    wait_byte(5, 500);
    for (int i = 0; i < N; i++) acc0[i] = accepts[i];
    cycle(1'b1, ~a);
    cycle(1'b0, rand128());
    wait_idle(1000);
    for (int i = 0; i < N; i++) chk_eq("no_accept_busy", i, accepts[i], acc0[i]);

    // valid held across the final done tick
    lat_cfg = 3;
    a = rand128();
    b = rand128();
    cycle(1'b1, a);
    wait_byte(15, 500);
    for (int i = 0; i < N; i++) acc0[i] = accepts[i];
    n = 0;
    while (n < 200 && (accepts[0] == acc0[0] || accepts[1] == acc0[1] || accepts[2] == acc0[2])) begin
      cycle(1'b1, b);
      n++;
    end
    cycle(1'b0, rand128());
    for (int i = 0; i < N; i++) chk_eq("held_valid_accept", i, accepts[i], acc0[i] + 1);
    wait_idle(1000);
    chk_eq("held_block_first", 0, first_byte[0], b[127:120]);

    // reset while waiting on byte 7
    lat_cfg = 20;
    cycle(1'b1, rand128());
    wait_byte(7, 1000);
    rst = 1'b1;
    model_clear();
    block_valid_i = 1'b0;
    cycle(1'b0, '0);
    chk_reset_vals();
    rst = 1'b0;
    start_cnt = 0;
    for (int k = 0; k < 30; k++) cycle(1'b0, rand128());
    chk_eq("no_start_after_reset", 0, start_cnt, 0);
    chk_eq("ready_after_reset", 0, {rdy[0], rdy[1], rdy[2]}, 3'b111);
    lat_cfg = 2;
    b = rand128();
    cycle(1'b1, b);
    wait_idle(1000);
    chk_eq("post_reset_first", 0, first_byte[0], b[127:120]);
    chk_eq("post_reset_first", 1, first_byte[1], b[7:0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
